// File: rtl/div_pkg.sv
// Shared constants and types for the sequential radix-2 divider.
// Imported by the divider top and its compare/subtract step.
package div_pkg;

  localparam int NBIT_DEF = 10;

  function automatic int cnt_w(input int n);
    return $clog2(n);
  endfunction

  localparam int CNT_W = cnt_w(NBIT_DEF);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in a dividend bit,
// then subtract the divisor if it fits.
module div_step
  import div_pkg::*;
#(
  parameter int NBIT = NBIT_DEF
) (
  input  logic [NBIT:0]   r,
  input  logic            bit_in,
  input  logic [NBIT-1:0] divisor,
  output logic [NBIT:0]   r_next,
  output logic            q_bit
);

  logic [NBIT+1:0] wide;
  logic [NBIT+1:0] diff;

  assign wide = {r, bit_in};
  assign diff = wide - {2'b00, divisor};

  // No borrow out of the subtraction means the divisor fits.
  assign q_bit  = ~diff[NBIT+1];
  assign r_next = q_bit ? diff[NBIT:0] : wide[NBIT:0];

endmodule

// File: rtl/seq_divider.sv
// Iterative unsigned divider: 2*NBIT-bit dividend by NBIT-bit
// divisor, one quotient bit per cycle, valid/ready on both sides.
module seq_divider
  import div_pkg::*;
#(
  parameter int NBIT = NBIT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2*NBIT-1:0] dividend,
  input  logic [NBIT-1:0]   divisor,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [NBIT-1:0]   quotient,
  output logic [NBIT-1:0]   remainder,
  output logic              ovf
);

  localparam int CW = cnt_w(NBIT);

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [NBIT:0]   r;
  logic [NBIT-1:0] sh;
  logic [NBIT-1:0] dsr;
  logic [NBIT-1:0] hi;
  logic [NBIT:0]   r_nxt;
  logic            q_bit;

  assign hi = dividend[2*NBIT-1:NBIT];

  div_step #(
    .NBIT(NBIT)
  ) u_step (
    .r      (r),
    .bit_in (sh[NBIT-1]),
    .divisor(dsr),
    .r_next (r_nxt),
    .q_bit  (q_bit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      ovf       <= 1'b0;
      cnt       <= '0;
      r         <= '0;
      sh        <= '0;
      dsr       <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            dsr      <= divisor;
            in_ready <= 1'b0;
            // Quotient cannot fit NBIT bits (or divisor is zero).
            if (hi >= divisor) begin
              state     <= DONE;
              out_valid <= 1'b1;
              ovf       <= 1'b1;
              quotient  <= '1;
              remainder <= '0;
            end else begin
              state <= BUSY;
              ovf   <= 1'b0;
              cnt   <= '0;
              r     <= {1'b0, hi};
              sh    <= dividend[NBIT-1:0];
            end
          end
        end
        BUSY: begin
          r        <= r_nxt;
          sh       <= {sh[NBIT-2:0], 1'b0};
          quotient <= {quotient[NBIT-2:0], q_bit};
          cnt      <= cnt + 1'b1;
          if (cnt == CW'(NBIT - 1)) begin
            state     <= DONE;
            out_valid <= 1'b1;
            remainder <= r_nxt[NBIT-1:0];
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
